// File: rtl/issue_pkg.sv
// Shared constants and types for the dual-issue instruction scheduler.
package issue_pkg;

    localparam int unsigned DEPTH_DEFAULT = 8;
    localparam int unsigned INSTR_W       = 32;
    localparam int unsigned REG_W         = 5;

    // Register-specifier field positions within an instruction word
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS1_MSB = 19;
    localparam int unsigned RS2_LSB = 20;
    localparam int unsigned RS2_MSB = 24;

    // Fetch-valid patterns; FV_BAD (younger without older) is treated as no fetch
    typedef enum logic [1:0] {
        FV_NONE = 2'b00,
        FV_ONE  = 2'b01,
        FV_BAD  = 2'b10,
        FV_TWO  = 2'b11
    } fetch_pat_e;

    function automatic logic [REG_W-1:0] rd_of(input logic [INSTR_W-1:0] instr);
        return instr[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [REG_W-1:0] rs1_of(input logic [INSTR_W-1:0] instr);
        return instr[RS1_MSB:RS1_LSB];
    endfunction

    function automatic logic [REG_W-1:0] rs2_of(input logic [INSTR_W-1:0] instr);
        return instr[RS2_MSB:RS2_LSB];
    endfunction

endpackage

// File: rtl/issue_dep_check.sv
// Read-after-write hazard detector between the two issue candidates.
module issue_dep_check
    import issue_pkg::*;
(
    input  logic [INSTR_W-1:0] older_instr,
    input  logic [INSTR_W-1:0] younger_instr,
    output logic               hazard
);

    logic [REG_W-1:0] older_rd;

    // Younger reads a register the older writes; x0 writes never create a dependency
    always_comb begin
        older_rd = rd_of(older_instr);
        hazard   = (older_rd != '0) &&
                   ((older_rd == rs1_of(younger_instr)) ||
                    (older_rd == rs2_of(younger_instr)));
    end

endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue in-order scheduler: circular instruction buffer feeding two
// issue slots, with slot2 held back on a RAW dependency on slot1.
module issue_scheduler
    import issue_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         fetch_valid,
    input  logic [INSTR_W-1:0] fetch_instr1,
    input  logic [INSTR_W-1:0] fetch_instr2,
    output logic               fetch_ready,
    input  logic               flush,
    input  logic               issue_ready,
    output logic [1:0]         issue_valid,
    output logic [INSTR_W-1:0] issue_instr1,
    output logic [INSTR_W-1:0] issue_instr2,
    output logic               dep_stall,
    output logic [31:0]        issued_cnt,
    output logic [15:0]        stall_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    logic [PTR_W-1:0]   head_p1;
    logic [PTR_W-1:0]   tail_p1;
    logic               has_one;
    logic               has_two;
    logic               hazard;
    logic [1:0]         push_cnt;
    logic [1:0]         pop_cnt;

    issue_dep_check u_dep_check (
        .older_instr   (mem[head]),
        .younger_instr (mem[head_p1]),
        .hazard        (hazard)
    );

    // Slot presentation and push/pop amounts, all from registered state
    always_comb begin
        head_p1      = head + 1'b1;
        tail_p1      = tail + 1'b1;
        has_one      = (count != '0);
        has_two      = (count >= CNT_W'(2));
        fetch_ready  = ((CNT_W'(DEPTH) - count) >= CNT_W'(2));

        dep_stall    = has_two && hazard;
        issue_valid  = {has_two && !hazard, has_one};
        issue_instr1 = has_one ? mem[head] : '0;
        issue_instr2 = issue_valid[1] ? mem[head_p1] : '0;

        push_cnt = 2'd0;
        if (fetch_ready) begin
            case (fetch_pat_e'(fetch_valid))
                FV_ONE:  push_cnt = 2'd1;
                FV_TWO:  push_cnt = 2'd2;
                default: push_cnt = 2'd0;
            endcase
        end

        pop_cnt = 2'd0;
        if (issue_ready) begin
            pop_cnt = {1'b0, issue_valid[0]} + {1'b0, issue_valid[1]};
        end
    end

    // Pointers, occupancy and statistics; flush wins over push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            issued_cnt <= '0;
            stall_cnt  <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head       <= head + PTR_W'(pop_cnt);
            tail       <= tail + PTR_W'(push_cnt);
            count      <= count + CNT_W'(push_cnt) - CNT_W'(pop_cnt);
            issued_cnt <= issued_cnt + 32'(pop_cnt);
            if (dep_stall && issue_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    // Buffer storage; not reset, occupancy alone decides what is live
    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            if (push_cnt != 2'd0) begin
                mem[tail] <= fetch_instr1;
            end
            if (push_cnt == 2'd2) begin
                mem[tail_p1] <= fetch_instr2;
            end
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: queue-based reference model,
// per-cycle output comparison, directed scenarios and random traffic.
module tb_issue_scheduler;
    import issue_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  fetch_valid;
    logic [31:0] fetch_instr1;
    logic [31:0] fetch_instr2;
    logic        fetch_ready;
    logic        flush;
    logic        issue_ready;
    logic [1:0]  issue_valid;
    logic [31:0] issue_instr1;
    logic [31:0] issue_instr2;
    logic        dep_stall;
    logic [31:0] issued_cnt;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic [31:0] m_issued;
    logic [15:0] m_stall;
    int          m_n;
    int          m_pops;
    bit          m_hz;
    bit          m_fr;

    // Compare-process locals
    int          c_n;
    logic [1:0]  e_valid;
    logic [31:0] e_i1;
    logic [31:0] e_i2;
    logic        e_dep;
    logic        e_fr;

    always #5 clk = ~clk;

    issue_scheduler #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_valid  (fetch_valid),
        .fetch_instr1 (fetch_instr1),
        .fetch_instr2 (fetch_instr2),
        .fetch_ready  (fetch_ready),
        .flush        (flush),
        .issue_ready  (issue_ready),
        .issue_valid  (issue_valid),
        .issue_instr1 (issue_instr1),
        .issue_instr2 (issue_instr2),
        .dep_stall    (dep_stall),
        .issued_cnt   (issued_cnt),
        .stall_cnt    (stall_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // RAW rule expressed with plain shifts and masks
    function automatic bit raw_hazard(input logic [31:0] a, input logic [31:0] b);
        int unsigned rd, s1, s2;
        rd = (a >> 7) & 32'h1f;
        s1 = (b >> 15) & 32'h1f;
        s2 = (b >> 20) & 32'h1f;
        return (rd != 0) && ((rd == s1) || (rd == s2));
    endfunction

    // Random instruction with register numbers 0..3 to make hazards common
    function automatic logic [31:0] rnd_instr();
        logic [31:0] x;
        x = $urandom;
        x[11:7]  = 5'($urandom_range(0, 3));
        x[19:15] = 5'($urandom_range(0, 3));
        x[24:20] = 5'($urandom_range(0, 3));
        return x;
    endfunction

    // Hazard-free tagged instruction (rd = x0)
    function automatic logic [31:0] tag_instr(input int k);
        return (32'(k) << 20) | 32'h33;
    endfunction

    // Reference model: queue of buffered instructions updated per edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_issued = '0;
            m_stall  = '0;
        end else begin
            m_n    = mq.size();
            m_fr   = (DEPTH - m_n) >= 2;
            m_hz   = (m_n >= 2) && raw_hazard(mq[0], mq[1]);
            m_pops = (m_n == 0) ? 0 : ((m_n == 1 || m_hz) ? 1 : 2);
            if (flush) begin
                mq.delete();
            end else begin
                if (issue_ready) begin
                    repeat (m_pops) void'(mq.pop_front());
                    m_issued += 32'(m_pops);
                    if (m_hz && m_stall != 16'hFFFF) m_stall++;
                end
                if (m_fr && fetch_valid[0]) begin
                    mq.push_back(fetch_instr1);
                    if (fetch_valid[1]) mq.push_back(fetch_instr2);
                end
            end
        end
    end

    // Compare every DUT output with the model on each falling edge
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            c_n     = mq.size();
            e_fr    = (DEPTH - c_n) >= 2;
            e_dep   = (c_n >= 2) && raw_hazard(mq[0], mq[1]);
            e_valid = {(c_n >= 2) && !e_dep, c_n >= 1};
            e_i1    = (c_n >= 1) ? mq[0] : 32'h0;
            e_i2    = e_valid[1] ? mq[1] : 32'h0;
            chk("fetch_ready", 32'(fetch_ready), 32'(e_fr));
            chk("issue_valid", 32'(issue_valid), 32'(e_valid));
            chk("issue_instr1", issue_instr1, e_i1);
            chk("issue_instr2", issue_instr2, e_i2);
            chk("dep_stall", 32'(dep_stall), 32'(e_dep));
            chk("issued_cnt", issued_cnt, m_issued);
            chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        end
    end

    // One clock: drive inputs, take the edge, settle just past the falling edge
    task automatic cyc(input logic [1:0] fv, input logic [31:0] a, input logic [31:0] b,
                       input logic fl, input logic ir);
        fetch_valid  = fv;
        fetch_instr1 = a;
        fetch_instr2 = b;
        flush        = fl;
        issue_ready  = ir;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && mq.size() != 0; i++) begin
            cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
        end
        chk("drain_empty", 32'(mq.size()), 32'h0);
    endtask

    logic [31:0] first_pushed;
    logic [31:0] saved_issued;

    initial begin
        rst_n        = 1'b0;
        fetch_valid  = 2'b00;
        fetch_instr1 = '0;
        fetch_instr2 = '0;
        flush        = 1'b0;
        issue_ready  = 1'b0;
        #1;
        chk("rst_issue_valid", 32'(issue_valid), 32'h0);
        chk("rst_fetch_ready", 32'(fetch_ready), 32'h1);
        chk("rst_issued_cnt", issued_cnt, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Independent pair issues together
        cyc(2'b11, 32'h00208033, 32'h00418133, 1'b0, 1'b1);
        chk("pair_valid", 32'(issue_valid), 32'h3);
        chk("pair_instr1", issue_instr1, 32'h00208033);
        chk("pair_instr2", issue_instr2, 32'h00418133);
        cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("pair_issued", issued_cnt, 32'h2);
        chk("pair_empty", 32'(issue_valid), 32'h0);

        // Dependent pair: slot2 withheld, then moves to slot1
        cyc(2'b11, 32'h002081B3, 32'h00318233, 1'b0, 1'b0);
        chk("haz_valid", 32'(issue_valid), 32'h1);
        chk("haz_dep_stall", 32'(dep_stall), 32'h1);
        chk("haz_instr2", issue_instr2, 32'h0);
        cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("haz_stall_cnt", 32'(stall_cnt), 32'h1);
        chk("haz_slot1", issue_instr1, 32'h00318233);
        chk("haz_valid2", 32'(issue_valid), 32'h1);
        drain();
        chk("haz_issued", issued_cnt, 32'h4);

        // Fill to DEPTH-1 with issue stalled; fetch must be refused
        first_pushed = rnd_instr();
        cyc(2'b01, first_pushed, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(2'b11, rnd_instr(), rnd_instr(), 1'b0, 1'b0);
        chk("full_ready", 32'(fetch_ready), 32'h0);
        chk("full_count", 32'(mq.size()), 32'(DEPTH - 1));
        cyc(2'b11, rnd_instr(), rnd_instr(), 1'b0, 1'b0);
        chk("full_ignored", 32'(mq.size()), 32'(DEPTH - 1));
        chk("full_head", issue_instr1, first_pushed);
        drain();

        // Steady state at count 4 with push 2 / pop 2, wrapping 3*DEPTH entries
        cyc(2'b11, tag_instr(1), tag_instr(2), 1'b0, 1'b0);
        cyc(2'b11, tag_instr(3), tag_instr(4), 1'b0, 1'b0);
        for (int k = 0; k < 3 * DEPTH / 2; k++) begin
            cyc(2'b11, tag_instr(5 + 2 * k), tag_instr(6 + 2 * k), 1'b0, 1'b1);
            chk("wrap_count", 32'(mq.size()), 32'h4);
        end
        chk("wrap_order", issue_instr1, tag_instr(3 * DEPTH + 1));
        drain();

        // Flush overrides same-edge push and pop
        cyc(2'b11, tag_instr(40), tag_instr(41), 1'b0, 1'b0);
        cyc(2'b11, tag_instr(42), tag_instr(43), 1'b0, 1'b0);
        saved_issued = m_issued;
        cyc(2'b11, tag_instr(44), tag_instr(45), 1'b1, 1'b1);
        chk("flush_valid", 32'(issue_valid), 32'h0);
        chk("flush_issued", issued_cnt, saved_issued);
        chk("flush_ready", 32'(fetch_ready), 32'h1);

        // Asynchronous reset with five entries buffered
        cyc(2'b01, rnd_instr(), 32'h0, 1'b0, 1'b0);
        cyc(2'b11, rnd_instr(), rnd_instr(), 1'b0, 1'b0);
        cyc(2'b11, rnd_instr(), rnd_instr(), 1'b0, 1'b0);
        chk("pre_rst_count", 32'(mq.size()), 32'h5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(issue_valid), 32'h0);
        chk("arst_instr1", issue_instr1, 32'h0);
        chk("arst_instr2", issue_instr2, 32'h0);
        chk("arst_dep", 32'(dep_stall), 32'h0);
        chk("arst_ready", 32'(fetch_ready), 32'h1);
        chk("arst_issued", issued_cnt, 32'h0);
        chk("arst_stall", 32'(stall_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cyc(2'b10, 32'h12345678, 32'h9abcdef0, 1'b0, 1'b1);
        chk("bad_fv_valid", 32'(issue_valid), 32'h0);
        cyc(2'b01, 32'h00000033, 32'h0, 1'b0, 1'b0);
        chk("resume_valid", 32'(issue_valid), 32'h1);
        chk("resume_instr1", issue_instr1, 32'h00000033);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            cyc(2'($urandom), rnd_instr(), rnd_instr(),
                ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 8, instruction-buffer entries (power of two, >=4).
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port fetch_valid  in  2  bit0 = fetch_instr1 valid, bit1 = fetch_instr2 valid.
REQ-005 SHALL have port fetch_instr1  in  32  older fetched instruction.
REQ-006 SHALL have port fetch_instr2  in  32  younger fetched instruction.
REQ-007 SHALL have port fetch_ready  out  1  buffer can accept two instructions this cycle.
REQ-008 SHALL have port flush  in  1  discard all buffered instructions.
REQ-009 SHALL have port issue_ready  in  1  issue stage consumes all valid slots this edge.
REQ-010 SHALL have port issue_valid  out  2  bit0 = slot1 valid, bit1 = slot2 valid.
REQ-011 SHALL have port issue_instr1  out  32  oldest buffered instruction, 0 when slot1 invalid.
REQ-012 SHALL have port issue_instr2  out  32  second-oldest instruction, 0 when slot2 invalid.
REQ-013 SHALL have port dep_stall  out  1  slot2 withheld due to RAW hazard this cycle.
REQ-014 SHALL have port issued_cnt  out  32  total instructions issued, wraps modulo 2^32.
REQ-015 SHALL have port stall_cnt  out  16  cycles with dep_stall=1 and issue_ready=1, saturating at 0xFFFF.

Function
REQ-016 SHALL buffer instructions in a DEPTH-entry circular FIFO, head/tail pointers wrap at DEPTH, occupancy count 0..DEPTH.
REQ-017 SHALL drive fetch_ready=1 iff DEPTH-count >= 2, evaluated from registered count (no dependency on same-cycle pops).
REQ-018 SHALL push on edge when fetch_ready=1: fetch_valid=01 pushes instr1; 11 pushes instr1 then instr2; 00 and illegal 10 push nothing.
REQ-019 SHALL ignore fetch_valid when fetch_ready=0 (no push, no error).
REQ-020 SHALL present head entry on slot1 when count>=1 and head+1 entry on slot2 when count>=2 and no hazard; outputs combinational from registered state, so an instruction pushed on edge k is issuable from cycle k+1.
REQ-021 SHALL flag hazard iff slot1 rd[11:7] != 0 and (rd == slot2 rs1[19:15] or rd == slot2 rs2[24:20]); hazard forces issue_valid[1]=0, issue_instr2=0, dep_stall=1.
REQ-022 SHALL never issue slot2 without slot1 (issue_valid=10 is unreachable).
REQ-023 SHALL pop popcount(issue_valid) entries on edge when issue_ready=1; withheld slot2 instruction becomes slot1 next cycle.
REQ-024 SHALL allow simultaneous push and pop: next count = count + pushes - pops, pointers update independently.
REQ-025 SHALL increment issued_cnt by popcount(issue_valid) on each pop edge.
REQ-026 SHALL, on flush=1, set count, head, tail to 0 next edge, overriding same-cycle push and pop; issued_cnt not incremented; stall_cnt unchanged.
REQ-027 SHALL drive issue_valid=00, dep_stall=0 when count=0; issue_valid=01 when count=1.

Reset
REQ-028 SHALL on rst_n=0 immediately clear count, head, tail, issued_cnt, stall_cnt; outputs then issue_valid=00, issue_instr1=issue_instr2=0, dep_stall=0, fetch_ready=1.
REQ-029 SHALL discard buffer contents on reset mid-operation; storage array need not be cleared.
REQ-030 SHALL resume normal pushes on the first rising edge after rst_n deasserts.

Structure
REQ-031 SHALL place DEPTH default, instruction field bit positions (RD, RS1, RS2) and instruction width constant in shared package issue_pkg.
REQ-032 SHALL implement hazard detection in combinational sub-module issue_dep_check (inputs: two instructions; output: hazard).
REQ-033 SHALL keep FIFO storage, pointers and counters in issue_scheduler itself.

Verification
REQ-034 SHALL cover: reset, push 11 with 0x00208033/0x00418133 (rd=x0 first), issue_ready=1 -> next cycle issue_valid=11, both issued, issued_cnt=2.
REQ-035 SHALL cover: push 11 with 0x002081B3 (rd=x3) / 0x00318233 (rs1=x3) -> issue_valid=01, dep_stall=1; after pop, 0x00318233 on slot1, stall_cnt=1.
REQ-036 SHALL cover: issue_ready=0, push pairs until count=DEPTH-1 -> fetch_ready=0; further fetch_valid=11 ignored; count unchanged.
REQ-037 SHALL cover: count=4, simultaneous push 11 and pop 2 -> count=4, pointers wrap correctly over 3*DEPTH instructions, order preserved.
REQ-038 SHALL cover: flush with push 11 and issue_ready=1 same edge -> count=0, issue_valid=00, issued_cnt unchanged.
REQ-039 SHALL cover: rst_n low mid-stream with count=5 -> outputs cleared asynchronously before next edge; fetch_valid=10 after reset pushes nothing.
